// File: rtl/led_shifter_ctrl_if.sv
// ---------------------------------------------------------------------------
// led_shifter_ctrl_if
// Bundles the LED shifter's board-facing signals.
//   key_right_n  raw KEY, active-low, press steps toward bit 0
//   key_left_n   raw KEY, active-low, press steps toward bit WIDTH-1
//   mode         00 manual-saturate, 01 manual-wrap, 10 auto-wrap, 11 auto-bounce
//   LEDR         one-hot LED bar
//   pos          binary index of the lit LED
//   dir_left     current auto direction (1 = toward MSB)
//   edge_hit     one-cycle pulse on blocked step, wrap or bounce reversal
// master: board/stimulus side (drives keys and mode)
// slave : the controller (drives the LED bar and status)
// ---------------------------------------------------------------------------
interface led_shifter_ctrl_if #(
   parameter int WIDTH = 10
) ();
   localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic             key_right_n;
   logic             key_left_n;
   logic [1:0]       mode;
   logic [WIDTH-1:0] LEDR;
   logic [PW-1:0]    pos;
   logic             dir_left;
   logic             edge_hit;

   modport master (
      output key_right_n, key_left_n, mode,
      input  LEDR, pos, dir_left, edge_hit
   );

   modport slave (
      input  key_right_n, key_left_n, mode,
      output LEDR, pos, dir_left, edge_hit
   );
endinterface

// File: rtl/led_shifter_ctrl.sv
// ---------------------------------------------------------------------------
// led_shifter_ctrl
// Keeps one lit LED in a WIDTH-bit bar and moves it on debounced KEY presses
// (manual modes) or on a free-running timer (auto modes).
// Ports:
//   CLOCK_50  system clock, all logic on the rising edge
//   reset     synchronous, active-high
//   bus       led_shifter_ctrl_if.slave: raw keys and mode in; LEDR, pos,
//             dir_left and edge_hit out, all registered
// ---------------------------------------------------------------------------
module led_shifter_ctrl #(
   parameter int WIDTH           = 10,
   parameter int START_POS       = 5,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int AUTO_PERIOD     = 25000000
) (
   input logic               CLOCK_50,
   input logic               reset,
   led_shifter_ctrl_if.slave bus
);
   localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TW = $clog2(AUTO_PERIOD);
   localparam logic [PW-1:0] POS_MAX = PW'(WIDTH - 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] TM_LAST = TW'(AUTO_PERIOD - 1);

   typedef enum logic [1:0] {
      M_SAT    = 2'b00,
      M_WRAP   = 2'b01,
      A_WRAP   = 2'b10,
      A_BOUNCE = 2'b11
   } mode_e;

   // Bit 0 = right key, bit 1 = left key throughout the input path.
   logic [1:0]    raw_n;
   logic [1:0]    sync_p0, sync_p1;
   logic [1:0]    stable_p2, stable_p3;
   logic [1:0]    press_p4;
   logic [CW-1:0] db_cnt [2];

   assign raw_n = {bus.key_left_n, bus.key_right_n};

   // Stage p0/p1: two-flop synchroniser; p2: debounced level; p3/p4: fall detect
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         sync_p0   <= 2'b11;
         sync_p1   <= 2'b11;
         stable_p2 <= 2'b11;
         stable_p3 <= 2'b11;
         press_p4  <= 2'b00;
         db_cnt[0] <= '0;
         db_cnt[1] <= '0;
      end else begin
         sync_p0   <= raw_n;
         sync_p1   <= sync_p0;
         stable_p3 <= stable_p2;
         // Registered one-cycle pulse on the debounced 1->0 transition only.
         press_p4  <= stable_p3 & ~stable_p2;
         for (int k = 0; k < 2; k++) begin
            if (sync_p1[k] == stable_p2[k]) begin
               db_cnt[k] <= '0;
            end else if (db_cnt[k] == DB_LAST) begin
               stable_p2[k] <= sync_p1[k];
               db_cnt[k]    <= '0;
            end else begin
               db_cnt[k] <= db_cnt[k] + CW'(1);
            end
         end
      end
   end

   mode_e            mode_cur, mode_q;
   logic [PW-1:0]    pos_q, pos_n;
   logic [WIDTH-1:0] led_q;
   logic [TW-1:0]    tmr_q, tmr_n;
   logic             dir_q, dir_n;
   logic             edge_q, edge_n;
   logic             go_r, go_l;

   assign mode_cur = mode_e'(bus.mode);
   // Simultaneous presses cancel each other in every mode.
   assign go_r = press_p4[0] & ~press_p4[1];
   assign go_l = press_p4[1] & ~press_p4[0];

   always_comb begin
      pos_n  = pos_q;
      dir_n  = dir_q;
      edge_n = 1'b0;
      tmr_n  = '0;
      if (mode_cur != mode_q) begin
         // Mode switch: restart the period, hold position and direction.
         tmr_n = '0;
      end else if (!mode_cur[1]) begin
         if (go_r) begin
            if (pos_q == '0) begin
               edge_n = 1'b1;
               if (mode_cur == M_WRAP) pos_n = POS_MAX;
            end else begin
               pos_n = pos_q - PW'(1);
            end
         end else if (go_l) begin
            if (pos_q == POS_MAX) begin
               edge_n = 1'b1;
               if (mode_cur == M_WRAP) pos_n = '0;
            end else begin
               pos_n = pos_q + PW'(1);
            end
         end
      end else begin
         // Direction is resolved before the tick so a coincident press steers it.
         if (go_r) dir_n = 1'b0;
         else if (go_l) dir_n = 1'b1;
         if (tmr_q == TM_LAST) begin
            tmr_n = '0;
            if (dir_n) begin
               if (pos_q == POS_MAX) begin
                  edge_n = 1'b1;
                  if (mode_cur == A_WRAP) begin
                     pos_n = '0;
                  end else begin
                     dir_n = 1'b0;
                     pos_n = pos_q - PW'(1);
                  end
               end else begin
                  pos_n = pos_q + PW'(1);
               end
            end else begin
               if (pos_q == '0) begin
                  edge_n = 1'b1;
                  if (mode_cur == A_WRAP) begin
                     pos_n = POS_MAX;
                  end else begin
                     dir_n = 1'b1;
                     pos_n = PW'(1);
                  end
               end else begin
                  pos_n = pos_q - PW'(1);
               end
            end
         end else begin
            tmr_n = tmr_q + TW'(1);
         end
      end
   end

   // Stage p5: position, bar, direction and status registers
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         mode_q <= mode_cur;
         pos_q  <= PW'(START_POS);
         led_q  <= WIDTH'(1) << START_POS;
         dir_q  <= 1'b0;
         edge_q <= 1'b0;
         tmr_q  <= '0;
      end else begin
         mode_q <= mode_cur;
         pos_q  <= pos_n;
         led_q  <= WIDTH'(1) << pos_n;
         dir_q  <= dir_n;
         edge_q <= edge_n;
         tmr_q  <= tmr_n;
      end
   end

   assign bus.LEDR     = led_q;
   assign bus.pos      = pos_q;
   assign bus.dir_left = dir_q;
   assign bus.edge_hit = edge_q;
endmodule
